// File: rtl/store_commit_buffer.sv
// Store commit buffer: a small circular FIFO of retired stores drained to the data
// cache over a req/ack handshake, with tail merging and store-to-load byte forwarding.
module store_commit_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W/8-1:0] in_mask,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_data,
  output logic                mem_req,
  output logic [DATA_W/8-1:0] mem_mask,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_data,
  input  logic                mem_ack,
  input  logic [ADDR_W-1:0]   ld_addr,
  output logic [DATA_W/8-1:0] ld_mask,
  output logic [DATA_W-1:0]   ld_data,
  output logic                empty
);

  localparam int MASK_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WA_W   = ADDR_W - 2;

  typedef enum logic {IDLE, REQ} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d, last_idx, fwd_idx;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WA_W-1:0]    addr_q [DEPTH];
  logic [WA_W-1:0]    addr_d [DEPTH];
  logic [DATA_W-1:0]  data_q [DEPTH];
  logic [DATA_W-1:0]  data_d [DEPTH];
  logic [MASK_W-1:0]  mask_q [DEPTH];
  logic [MASK_W-1:0]  mask_d [DEPTH];
  logic               mem_req_q, mem_req_d;
  logic [MASK_W-1:0]  mem_mask_q, mem_mask_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_data_q, mem_data_d;
  logic               merge_ok, accept, push_new, pop;
  logic [DATA_W-1:0]  in_lane_mask;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{in_addr[1:0], ld_addr[1:0]};

  // The entry being written to the cache must not change underneath the request.
  assign last_idx = tail_q - PTR_W'(1);
  assign merge_ok = (count_q != '0) && (addr_q[last_idx] == in_addr[ADDR_W-1:2]) &&
                    !((state_q == REQ) && (last_idx == head_q));
  assign in_ready = (count_q != CNT_W'(DEPTH)) || merge_ok;
  assign accept   = in_valid && in_ready;
  assign push_new = accept && !merge_ok && (in_mask != '0);
  assign pop      = (state_q == REQ) && mem_ack;
  assign empty    = (count_q == '0) && (state_q == IDLE);

  assign mem_req  = mem_req_q;
  assign mem_mask = mem_mask_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;

  always_comb begin
    in_lane_mask = '0;
    for (int b = 0; b < MASK_W; b++) in_lane_mask[b*8 +: 8] = {8{in_mask[b]}};
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    mask_d     = mask_q;
    mem_req_d  = mem_req_q;
    mem_mask_d = mem_mask_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;

    if (accept && merge_ok) begin
      mask_d[last_idx] = mask_q[last_idx] | in_mask;
      data_d[last_idx] = (data_q[last_idx] & ~in_lane_mask) | (in_data & in_lane_mask);
    end else if (push_new) begin
      addr_d[tail_q] = in_addr[ADDR_W-1:2];
      data_d[tail_q] = in_data & in_lane_mask;
      mask_d[tail_q] = in_mask;
      tail_d         = tail_q + PTR_W'(1);
    end

    // Launch from the next-state entry so a same-cycle merge into the head is not lost.
    unique case (state_q)
      IDLE: if (count_q != '0) begin
        state_d    = REQ;
        mem_req_d  = 1'b1;
        mem_mask_d = mask_d[head_q];
        mem_addr_d = {addr_d[head_q], 2'b00};
        mem_data_d = data_d[head_q];
      end
      REQ: if (mem_ack) begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        head_d    = head_q + PTR_W'(1);
      end
      default: state_d = IDLE;
    endcase

    unique case ({push_new, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_mask_q <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      mem_req_q  <= mem_req_d;
      mem_mask_q <= mem_mask_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
    end
  end

  // Walk oldest to youngest so younger stores overwrite older bytes.
  always_comb begin
    ld_mask = '0;
    ld_data = '0;
    fwd_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_q[fwd_idx] == ld_addr[ADDR_W-1:2])) begin
        for (int b = 0; b < MASK_W; b++) begin
          if (mask_q[fwd_idx][b]) begin
            ld_mask[b]        = 1'b1;
            ld_data[b*8 +: 8] = data_q[fwd_idx][b*8 +: 8];
          end
        end
      end
    end
  end

endmodule
